arbiter_out_buffer: RTL and testbench

//  Elastic FIFO stage directly downstream of the N-way arbiter. Accepts the arbiter's merged valid/data stream
//  and decouples it from the consumer's ready, so arbiter grants never see downstream combinational ready paths.

---
 rtl/arbiter_pkg.sv | 8 +
 rtl/arbiter_buf_mem.sv | 20 ++
 rtl/arbiter_out_buffer.sv | 78 +++++++
 tb/tb_arbiter_out_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// arbiter_pkg: pointer-width helper and default occupancy type shared by the arbiter blocks and their benches
package arbiter_pkg;
  localparam int DEF_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  typedef logic [ptr_w(DEF_DEPTH):0] count_t;
endpackage

// File: rtl/arbiter_buf_mem.sv
// arbiter_buf_mem: DEPTH x DWIDTH register file, one write port, one async read port, no reset
module arbiter_buf_mem
  import arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DWIDTH-1:0]         rdata
);
  logic [DWIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/arbiter_out_buffer.sv
// arbiter_out_buffer: elastic FIFO after the arbiter, generating its priority-rotation pulse.
// Optional ARBITER_OUT_BUFFER_STATS_EN adds push counter and occupancy high-water mark.
module arbiter_out_buffer
  import arbiter_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int DEPTH        = 4,
  parameter int SHIFT_PERIOD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DWIDTH-1:0]       in_data,
  output logic                    in_ready,
  output logic                    shift,
  output logic                    out_valid,
  output logic [DWIDTH-1:0]       out_data,
  input  logic                    out_ready,
`ifdef ARBITER_OUT_BUFFER_STATS_EN
  output logic [31:0]             stat_pushes,
  output logic [ptr_w(DEPTH):0]   stat_max_count,
`endif
  output logic [ptr_w(DEPTH):0]   count
);
  localparam int PW  = ptr_w(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = SHIFT_PERIOD > 1 ? $clog2(SHIFT_PERIOD) : 1;
  localparam logic [SCW-1:0] SLAST = SCW'(SHIFT_PERIOD - 1);
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [SCW-1:0]    r_shift_cnt;
  logic              w_push, w_pop;
  logic [DWIDTH-1:0] w_rdata;
  // ready depends only on registered occupancy, keeping the arbiter free of consumer paths
  assign in_ready  = r_count != CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign shift     = w_push & (r_shift_cnt == SLAST);
  assign out_data  = out_valid ? w_rdata : '0;
  assign count     = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_shift_cnt <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PW'(w_push);
      r_rd_ptr    <= r_rd_ptr + PW'(w_pop);
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_shift_cnt <= !w_push ? r_shift_cnt : (r_shift_cnt == SLAST) ? '0 : r_shift_cnt + 1'b1;
    end
  end
  arbiter_buf_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_push & ~rst),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );
`ifdef ARBITER_OUT_BUFFER_STATS_EN
  logic [31:0]   r_stat_pushes;
  logic [CW-1:0] r_stat_max;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pushes <= '0;
      r_stat_max    <= '0;
    end else begin
      r_stat_pushes <= (w_push && r_stat_pushes != '1) ? r_stat_pushes + 1'b1 : r_stat_pushes;
      r_stat_max    <= (r_count > r_stat_max) ? r_count : r_stat_max;
    end
  end
  assign stat_pushes    = r_stat_pushes;
  assign stat_max_count = r_stat_max;
`endif
endmodule

// File: tb/tb_arbiter_out_buffer.sv
// tb_arbiter_out_buffer: scoreboard bench for arbiter_out_buffer; covers stats when ARBITER_OUT_BUFFER_STATS_EN is defined
module tb_arbiter_out_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int SP = 3;
  logic clk, rst, in_valid, in_ready, shift, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [2:0] count;
  logic in_ready1, shift1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [2:0] count1;
`ifdef ARBITER_OUT_BUFFER_STATS_EN
  logic [31:0] stat_pushes, stat_pushes1;
  logic [2:0] stat_max_count, stat_max_count1;
`endif
  int errors = 0, checks = 0, npush = 0;
  logic exp_push = 0, exp_shift = 0;
  logic [DW-1:0] sb[$];

  arbiter_out_buffer #(.DWIDTH(DW), .DEPTH(DEPTH), .SHIFT_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .shift(shift), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef ARBITER_OUT_BUFFER_STATS_EN
    .stat_pushes(stat_pushes), .stat_max_count(stat_max_count),
`endif
    .count(count));

  arbiter_out_buffer #(.DWIDTH(DW), .DEPTH(DEPTH), .SHIFT_PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .shift(shift1), .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
`ifdef ARBITER_OUT_BUFFER_STATS_EN
    .stat_pushes(stat_pushes1), .stat_max_count(stat_max_count1),
`endif
    .count(count1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // inputs change at the falling edge; the reference FIFO is updated at the rising edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    exp_push = v && (sb.size() != DEPTH);
    exp_shift = exp_push && (npush % SP == SP - 1);
    @(posedge clk);
    if (exp_push) begin
      sb.push_back(d);
      npush++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v, input logic [DW-1:0] d);
    in_valid = v; in_data = d; out_ready = 0; rst = 1;
    exp_push = 0; exp_shift = 0;
    @(posedge clk);
    sb.delete();
    npush = 0;
    @(negedge clk);
    rst = 0; in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(0, 0, 1);
    chk("drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("count", count, sb.size());
      chk("in_ready", in_ready, sb.size() != DEPTH);
      chk("out_valid", out_valid, sb.size() != 0);
      chk("shift", shift, exp_shift);
      chk("shift_p1", shift1, exp_push);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got data %0h required none", out_data);
        end else begin
          chk("head", out_data, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end else chk("out_data_zero", out_data, 0);
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
    @(negedge clk);
    do_reset(0, 0);
    // fill to three with no consumer
    for (int i = 1; i <= 3; i++) step(1, DW'(i), 0);
    // full, then a single pop while the producer keeps pushing
    step(1, 16'h0004, 0);
    step(1, 16'h0005, 1);
    step(1, 16'h0005, 0);
    drain();
    // steady push/pop at occupancy two across pointer wrap
    step(1, 16'h0a00, 0);
    step(1, 16'h0a01, 0);
    for (int i = 2; i < 12; i++) step(1, 16'h0a00 + DW'(i), 1);
    drain();
    // shift pattern from a fresh reset
    do_reset(0, 0);
    for (int i = 0; i < 7; i++) step(1, 16'h0b00 + DW'(i), 1);
    drain();
    // reset with data inside and a push pending
    for (int i = 0; i < 3; i++) step(1, 16'h0c00 + DW'(i), 0);
    do_reset(1, 16'hdead);
    for (int i = 0; i < 4; i++) step(1, 16'h0d00 + DW'(i), i[0]);
    drain();
    // randomized traffic with two ready biases
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
    drain();
`ifdef ARBITER_OUT_BUFFER_STATS_EN
    do_reset(0, 0);
    #1;
    chk("stat_pushes_rst", stat_pushes, 0);
    chk("stat_max_rst", stat_max_count, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h0e00 + DW'(i), 0);
    for (int i = 3; i < 5; i++) step(1, 16'h0e00 + DW'(i), 1);
    drain();
    step(0, 0, 0);
    #1;
    chk("stat_pushes", stat_pushes, 5);
    chk("stat_max", stat_max_count, 3);
    dut.r_stat_pushes = '1;
    step(1, 16'h0f00, 0);
    #1;
    chk("stat_sat", stat_pushes, 32'hffff_ffff);
    drain();
`endif
    step(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
